// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / CPU flag-register decode and the receive FIFO.
// The master drives the strobes and the FIFO (slave) returns head data and status.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  pop;
    logic                  flush;
    logic                  ovf_clr;
    logic [7:0]            dout;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output rx_valid, rx_data, pop, flush, ovf_clr,
        input  dout, empty, full, count, overflow
    );

    modport slave (
        input  rx_valid, rx_data, pop, flush, ovf_clr,
        output dout, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO: absorbs UART bursts so a slow-polling CPU sees bytes in order,
// with a sticky overflow flag for bytes lost while full.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;

    logic do_pop;
    logic do_push;
    logic drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    always_comb begin
        do_pop  = bus.pop & (count_q != '0);
        do_push = bus.rx_valid & ((count_q != CNT_FULL) | do_pop);
        drop    = bus.rx_valid & ~do_push;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push)
                count_q <= count_q - CNT_ONE;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.ovf_clr)
                overflow_q <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset; stale entries are masked by count.
    always_ff @(posedge clk_sys) begin
        if (do_push && !bus.flush)
            mem[wr_ptr] <= bus.rx_data;
    end

    always_comb begin
        bus.dout     = (count_q != '0) ? mem[rd_ptr] : 8'h00;
        bus.empty    = (count_q == '0);
        bus.full     = (count_q == CNT_FULL);
        bus.count    = count_q;
        bus.overflow = overflow_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk_sys;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    logic [7:0] mq[$];
    logic       movf;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] model_vec();
        int n;
        n = mq.size();
        return {(n != 0) ? mq[0] : 8'h00, 1'(n == 0), 1'(n == DEPTH), 5'(n), movf};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.dout, bus.empty, bus.full, bus.count, bus.overflow};
    endfunction

    // Drives one cycle of strobes, advances the reference model at the edge, then releases the strobes.
    task automatic step(input logic v, input logic [7:0] d, input logic p, input logic f, input logic c);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.pop      = p;
        bus.flush    = f;
        bus.ovf_clr  = c;
        @(posedge clk_sys);
        if (f) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (c) movf = 1'b0;
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else movf = 1'b1;
            end
        end
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = $urandom_range(0, 255);
        bus.pop      = 1'b0;
        bus.flush    = 1'b0;
        bus.ovf_clr  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b1;
        mq.delete();
        movf = 1'b0;
        #1;
        tests_run++;
        if (dut_vec() !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %h want %h", dut_vec(), {8'h00, 1'b1, 1'b0, 5'd0, 1'b0});
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL pop_empty: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_ordering_wrap();
        int errs;
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.dout !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL fill16: got full=%b count=%0d dout=%h want full=1 count=16 dout=10",
                     bus.full, bus.count, bus.dout);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] want;
            want = (i < 6) ? 8'h1A + 8'(i) : 8'h20 + 8'(i - 6);
            tests_run++;
            if (bus.dout !== want || dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("[TB] FAIL wrap_order[%0d]: got dout=%h vec=%h want dout=%h vec=%h",
                         i, bus.dout, dut_vec(), want, model_vec());
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if (bus.empty !== 1'b1 || bus.dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL wrap_drained: got empty=%b dout=%h want empty=1 dout=00", bus.empty, bus.dout);
        end
    endtask

    task automatic test_overflow();
        logic seen_aa;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 127)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd16 || bus.overflow !== 1'b1 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL overflow_set: got %h want %h", dut_vec(), model_vec());
        end
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clr_vs_drop: got overflow=%b want 1", bus.overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.overflow !== 1'b0 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clr_alone: got %h want %h", dut_vec(), model_vec());
        end
        seen_aa = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.dout === 8'hAA) seen_aa = 1'b1;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if (seen_aa !== 1'b0 || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dropped_byte_absent: got seen_aa=%b empty=%b want 0 1", seen_aa, bus.empty);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] last;
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop: got %h want %h", dut_vec(), model_vec());
        end
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = bus.dout;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if (last !== 8'h55 || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop_last: got last=%h empty=%b want 55 1", last, bus.empty);
        end
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd1 || bus.dout !== 8'h66 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL empty_push_pop: got %h want count=1 dout=66 (%h)", dut_vec(), model_vec());
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (bus.count !== 5'd1 || dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (dut_vec() !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL flush_priority: got %h want %h", dut_vec(), {8'h00, 1'b1, 1'b0, 5'd0, 1'b0});
        end
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.dout !== 8'h77 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL push_after_flush: got %h want dout=77 (%h)", dut_vec(), model_vec());
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd9 || bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_state: got count=%0d ovf=%b want 9 1", bus.count, bus.overflow);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (dut_vec() !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h want %h", dut_vec(), {8'h00, 1'b1, 1'b0, 5'd0, 1'b0});
        end
        mq.delete();
        movf = 1'b0;
        #3 reset_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.dout !== 8'h3C || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_push: got %h want %h", dut_vec(), model_vec());
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_pop: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 8));
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        movf         = 1'b0;
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.pop      = 1'b0;
        bus.flush    = 1'b0;
        bus.ovf_clr  = 1'b0;
        test_reset();
        test_ordering_wrap();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
